// File: rtl/regfile.sv
// regfile: 2-read/1-write register file with hard-wired zero register,
// dedicated PC increment path and per-register pending-write scoreboard.
`default_nettype none

module regfile #(
  parameter int          DAT_WIDTH = 64,
  parameter int          REG_COUNT = 32,
  parameter int          PC_ID     = 31,
  parameter logic [63:0] PC_RESET  = 64'h800000000000,
  parameter int          PC_STEP   = 8,
  localparam int         IW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IW-1:0]        ra_id_i,
  output logic [DAT_WIDTH-1:0] ra_dat_o,
  output logic                 ra_busy_o,
  input  logic [IW-1:0]        rb_id_i,
  output logic [DAT_WIDTH-1:0] rb_dat_o,
  output logic                 rb_busy_o,
  input  logic                 we_i,
  input  logic [IW-1:0]        wr_id_i,
  input  logic [DAT_WIDTH-1:0] wr_dat_i,
  input  logic                 pc_inc_i,
  output logic [DAT_WIDTH-1:0] pc_o,
  input  logic                 lock_i,
  input  logic [IW-1:0]        lock_id_i
);

  localparam logic [DAT_WIDTH-1:0] PC_RST_VAL = DAT_WIDTH'(PC_RESET);
  localparam logic [DAT_WIDTH-1:0] PC_INC_VAL = DAT_WIDTH'(PC_STEP);
  localparam logic [IW-1:0]        PC_IDX     = IW'(PC_ID);

  logic [DAT_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0] busy;

  // Post-edge value of a valid, non-zero register: write beats PC increment.
  function automatic logic [DAT_WIDTH-1:0] next_dat(input logic [IW-1:0] idx);
    if (we_i && (wr_id_i == idx))
      return wr_dat_i;
    else if (pc_inc_i && (idx == PC_IDX))
      return regs[idx] + PC_INC_VAL;
    else
      return regs[idx];
  endfunction

  // A lock on the same cycle as a write marks a new outstanding write.
  function automatic logic next_busy(input logic [IW-1:0] idx);
    if (lock_i && (lock_id_i == idx))
      return 1'b1;
    else if (we_i && (wr_id_i == idx))
      return 1'b0;
    else
      return busy[idx];
  endfunction

  function automatic logic idx_valid(input logic [IW-1:0] idx);
    return (idx != '0) && (32'(idx) < REG_COUNT);
  endfunction

  function automatic logic [DAT_WIDTH-1:0] rd_dat(input logic [IW-1:0] idx);
    return idx_valid(idx) ? next_dat(idx) : '0;
  endfunction

  function automatic logic rd_busy(input logic [IW-1:0] idx);
    return idx_valid(idx) ? next_busy(idx) : 1'b0;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= ((i == PC_ID) && (i != 0)) ? PC_RST_VAL : '0;
        busy[i] <= 1'b0;
      end
      ra_dat_o  <= '0;
      rb_dat_o  <= '0;
      ra_busy_o <= 1'b0;
      rb_busy_o <= 1'b0;
    end else begin
      // Register 0 is never updated; it stays at its reset value of zero.
      for (int i = 1; i < REG_COUNT; i++) begin
        regs[i] <= next_dat(IW'(i));
        busy[i] <= next_busy(IW'(i));
      end
      ra_dat_o  <= rd_dat(ra_id_i);
      rb_dat_o  <= rd_dat(rb_id_i);
      ra_busy_o <= rd_busy(ra_id_i);
      rb_busy_o <= rd_busy(rb_id_i);
    end
  end

  assign pc_o = regs[PC_IDX];

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// tb_regfile: directed vector table plus hand-written reset sequences for regfile.
`default_nettype none

module tb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  ra_id_i, rb_id_i, wr_id_i, lock_id_i;
  logic [63:0] ra_dat_o, rb_dat_o, wr_dat_i, pc_o;
  logic        ra_busy_o, rb_busy_o, we_i, pc_inc_i, lock_i;

  localparam logic [63:0] PCR = 64'h800000000000;

  regfile dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ra_id_i(ra_id_i), .ra_dat_o(ra_dat_o), .ra_busy_o(ra_busy_o),
    .rb_id_i(rb_id_i), .rb_dat_o(rb_dat_o), .rb_busy_o(rb_busy_o),
    .we_i(we_i), .wr_id_i(wr_id_i), .wr_dat_i(wr_dat_i),
    .pc_inc_i(pc_inc_i), .pc_o(pc_o),
    .lock_i(lock_i), .lock_id_i(lock_id_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  wr_id;
    logic [63:0] wr_dat;
    logic        pc_inc;
    logic        lock;
    logic [4:0]  lock_id;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [63:0] exp_ra;
    logic        exp_rab;
    logic [63:0] exp_rb;
    logic        exp_rbb;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input int n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s[%0d]: got 0x%h required 0x%h", nm, n, got, exp);
  endtask

  task automatic add(input logic we, input logic [4:0] wid, input logic [63:0] wd,
                     input logic inc, input logic lk, input logic [4:0] lid,
                     input logic [4:0] ra, input logic [4:0] rb,
                     input logic [63:0] era, input logic erab,
                     input logic [63:0] erb, input logic erbb, input logic [63:0] epc);
    vec_t v;
    v.we = we; v.wr_id = wid; v.wr_dat = wd; v.pc_inc = inc; v.lock = lk; v.lock_id = lid;
    v.ra = ra; v.rb = rb; v.exp_ra = era; v.exp_rab = erab; v.exp_rb = erb;
    v.exp_rbb = erbb; v.exp_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [4:0] wid, input logic [63:0] wd,
                       input logic inc, input logic lk, input logic [4:0] lid,
                       input logic [4:0] ra, input logic [4:0] rb);
    we_i = we; wr_id_i = wid; wr_dat_i = wd; pc_inc_i = inc;
    lock_i = lk; lock_id_i = lid; ra_id_i = ra; rb_id_i = rb;
  endtask

  task automatic chk_all(input string nm, input int n, input logic [63:0] era, input logic erab,
                         input logic [63:0] erb, input logic erbb, input logic [63:0] epc);
    chk({nm, ".ra_dat"}, n, ra_dat_o, era);
    chk({nm, ".ra_busy"}, n, 64'(ra_busy_o), 64'(erab));
    chk({nm, ".rb_dat"}, n, rb_dat_o, erb);
    chk({nm, ".rb_busy"}, n, 64'(rb_busy_o), 64'(erbb));
    chk({nm, ".pc"}, n, pc_o, epc);
  endtask

  initial begin
    rst_i = 1'b0;
    drive(1'b1, 5'd3, 64'hFFFF, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3);
    repeat (2) @(posedge clk_i);
    #1 chk_all("reset_hold", 0, 64'h0, 1'b0, 64'h0, 1'b0, PCR);
    @(negedge clk_i);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
    rst_i = 1'b1;

    //  we wid   wdat                   inc lk lid  ra     rb     exp_ra                 b  exp_rb         b  exp_pc
    add(0, 5'd0, 64'h0,                 0, 0, 5'd0, 5'd5,  5'd0,  64'h0,                 0, 64'h0,        0, PCR);
    add(1, 5'd3, 64'hDEADBEEF,          0, 0, 5'd0, 5'd5,  5'd0,  64'h0,                 0, 64'h0,        0, PCR);
    add(0, 5'd0, 64'h0,                 0, 0, 5'd0, 5'd3,  5'd3,  64'hDEADBEEF,          0, 64'hDEADBEEF, 0, PCR);
    add(1, 5'd0, 64'h1234,              0, 0, 5'd0, 5'd0,  5'd3,  64'h0,                 0, 64'hDEADBEEF, 0, PCR);
    add(0, 5'd0, 64'h0,                 0, 0, 5'd0, 5'd0,  5'd0,  64'h0,                 0, 64'h0,        0, PCR);
    add(1, 5'd7, 64'hA5,                0, 0, 5'd0, 5'd7,  5'd3,  64'hA5,                0, 64'hDEADBEEF, 0, PCR);
    add(0, 5'd0, 64'h0,                 1, 0, 5'd0, 5'd31, 5'd7,  64'h800000000008,      0, 64'hA5,       0, 64'h800000000008);
    add(0, 5'd0, 64'h0,                 1, 0, 5'd0, 5'd31, 5'd7,  64'h800000000010,      0, 64'hA5,       0, 64'h800000000010);
    add(0, 5'd0, 64'h0,                 1, 0, 5'd0, 5'd31, 5'd0,  64'h800000000018,      0, 64'h0,        0, 64'h800000000018);
    add(1, 5'd31, 64'h100,              1, 0, 5'd0, 5'd31, 5'd0,  64'h100,               0, 64'h0,        0, 64'h100);
    add(1, 5'd31, 64'hFFFFFFFFFFFFFFF8, 0, 0, 5'd0, 5'd31, 5'd0,  64'hFFFFFFFFFFFFFFF8,  0, 64'h0,        0, 64'hFFFFFFFFFFFFFFF8);
    add(0, 5'd0, 64'h0,                 1, 0, 5'd0, 5'd31, 5'd0,  64'h0,                 0, 64'h0,        0, 64'h0);
    add(0, 5'd0, 64'h0,                 0, 1, 5'd9, 5'd9,  5'd3,  64'h0,                 1, 64'hDEADBEEF, 0, 64'h0);
    add(0, 5'd0, 64'h0,                 0, 0, 5'd0, 5'd9,  5'd9,  64'h0,                 1, 64'h0,        1, 64'h0);
    add(1, 5'd9, 64'h42,                0, 0, 5'd0, 5'd9,  5'd9,  64'h42,                0, 64'h42,       0, 64'h0);
    add(1, 5'd9, 64'h55,                0, 1, 5'd9, 5'd9,  5'd0,  64'h55,                1, 64'h0,        0, 64'h0);
    add(0, 5'd0, 64'h0,                 0, 1, 5'd0, 5'd0,  5'd9,  64'h0,                 0, 64'h55,       1, 64'h0);
    add(1, 5'd9, 64'h66,                0, 1, 5'd10, 5'd9, 5'd10, 64'h66,                0, 64'h0,        1, 64'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wr_id, vecs[i].wr_dat, vecs[i].pc_inc,
            vecs[i].lock, vecs[i].lock_id, vecs[i].ra, vecs[i].rb);
      @(posedge clk_i);
      #1 chk_all("vec", i, vecs[i].exp_ra, vecs[i].exp_rab, vecs[i].exp_rb, vecs[i].exp_rbb, vecs[i].exp_pc);
    end

    // Asynchronous reset arriving between edges while a write to r4 is pending.
    drive(1'b1, 5'd4, 64'h77, 1'b0, 1'b0, 5'd0, 5'd4, 5'd10);
    @(posedge clk_i);
    #1 chk_all("pre_rst", 0, 64'h77, 1'b0, 64'h0, 1'b1, 64'h0);
    drive(1'b1, 5'd4, 64'h88, 1'b1, 1'b1, 5'd4, 5'd4, 5'd10);
    #2 rst_i = 1'b0;
    #1 chk_all("async_rst", 0, 64'h0, 1'b0, 64'h0, 1'b0, PCR);
    @(posedge clk_i);
    #1 chk_all("async_rst", 1, 64'h0, 1'b0, 64'h0, 1'b0, PCR);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd10);
    @(posedge clk_i);
    #1 chk_all("post_rst", 0, 64'h0, 1'b0, 64'h0, 1'b0, PCR);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd3);
    @(posedge clk_i);
    #1 chk_all("post_rst", 1, 64'h0, 1'b0, 64'h0, 1'b0, PCR);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
